spi_master_cs: RTL and testbench

Byte-level SPI master with automatic chip-select that sits directly downstream of the SPI sequencing controller. It accepts bytes over a TX_DV/TX_Ready handshake, holds CS low across a multi-byte transaction, serialises MSB-first on MOSI, and returns captured MISO bytes with a per-byte pulse. It drives the ADC/DAC pins on the board header.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_byte_engine.sv | 115 +++++++++++
 rtl/spi_master_cs.sv | 146 ++++++++++++++
 tb/tb_spi_master_cs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master types, mode constants and clock-phase helpers
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        TRANSFER    = 2'd1,
        CS_INACTIVE = 2'd2
    } spi_state_t;

    localparam int MODE0 = 0;
    localparam int MODE1 = 1;
    localparam int MODE2 = 2;
    localparam int MODE3 = 3;

    // Clock polarity: SCLK idle level
    function automatic logic get_cpol(input int mode);
        return (mode == MODE2) || (mode == MODE3);
    endfunction

    // Clock phase: 1 means data launches on the leading edge and is sampled on the trailing edge
    function automatic logic get_cpha(input int mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - one-byte SCLK/MOSI/MISO shifter; receive capture only when SPI_RX_EN is defined
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       sys_clk,
    input  logic       i_Rst_L,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_last_edge,
    output logic       o_done,
    output logic [7:0] o_rx_byte
);

    localparam logic CPOL = get_cpol(SPI_MODE);
    localparam logic CPHA = get_cpha(SPI_MODE);
    localparam int   ECW  = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [ECW-1:0] LEAD_AT  = ECW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [ECW-1:0] TRAIL_AT = ECW'(2 * CLKS_PER_HALF_BIT - 1);

    logic           active;
    logic [ECW-1:0] edge_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     tx_shift;
    logic           lead_edge;
    logic           trail_edge;
    logic           launch_edge;

    // edge_cnt spans one SCLK period; the leading edge lands mid-period, the trailing edge at its end
    assign lead_edge   = active && (edge_cnt == LEAD_AT);
    assign trail_edge  = active && (edge_cnt == TRAIL_AT);
    assign launch_edge = CPHA ? lead_edge : trail_edge;
    assign o_last_edge = trail_edge && (bit_cnt == 3'd7);

    // SCLK generation, MOSI launch and byte-done pulse
    always_ff @(posedge sys_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            active   <= 1'b0;
            edge_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            o_sclk   <= CPOL;
            o_mosi   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= o_last_edge;
            if (i_start) begin
                active   <= 1'b1;
                edge_cnt <= '0;
                bit_cnt  <= 3'd0;
                if (CPHA) begin
                    // bit 7 waits for the first (leading) edge
                    tx_shift <= i_byte;
                end else begin
                    o_mosi   <= i_byte[7];
                    tx_shift <= {i_byte[6:0], 1'b0};
                end
            end else if (active) begin
                if (lead_edge || trail_edge) begin
                    o_sclk <= ~o_sclk;
                end
                if (launch_edge) begin
                    o_mosi   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
                if (trail_edge) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end
                end else begin
                    edge_cnt <= edge_cnt + ECW'(1);
                end
            end
        end
    end

`ifdef SPI_RX_EN
    logic [7:0] rx_shift;
    logic [7:0] rx_sample;
    logic       sample_edge;

    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign rx_sample   = {rx_shift[6:0], i_miso};

    // MISO capture; in CPHA=1 the final sample coincides with the last edge, so it is folded in directly
    always_ff @(posedge sys_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_shift  <= 8'h00;
            o_rx_byte <= 8'h00;
        end else begin
            if (i_start) begin
                rx_shift <= 8'h00;
            end else if (sample_edge) begin
                rx_shift <= rx_sample;
            end
            if (o_last_edge) begin
                o_rx_byte <= CPHA ? rx_sample : rx_shift;
            end
        end
    end
`else
    logic unused_miso;

    assign unused_miso = i_miso;
    assign o_rx_byte   = 8'h00;
`endif

endmodule

// File: rtl/spi_master_cs.sv
// rtl/spi_master_cs.sv - SPI master with automatic multi-byte chip select; receive path gated by SPI_RX_EN
module spi_master_cs
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 2,
    parameter int CS_INACTIVE_CLKS  = 1
) (
    input  logic                                  sys_clk,
    input  logic                                  i_Rst_L,
    input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_TX_Count,
    input  logic [7:0]                            i_TX_Byte,
    input  logic                                  i_TX_DV,
    output logic                                  o_TX_Ready,
    output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count,
    output logic                                  o_RX_DV,
    output logic [7:0]                            o_RX_Byte,
    output logic                                  o_SPI_Clk,
    input  logic                                  i_SPI_MISO,
    output logic                                  o_SPI_MOSI,
    output logic                                  o_SPI_CS_n
);

    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int IW = $clog2(CS_INACTIVE_CLKS + 2);

    spi_state_t    state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic [IW-1:0] inact_q, inact_d;
    logic          cs_n_q, cs_n_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] count_clamped;
    logic          accept;
    logic          last_edge;

    assign accept     = i_TX_DV && ready_q;
    assign o_TX_Ready = ready_q;
    assign o_SPI_CS_n = cs_n_q;
    assign o_RX_Count = rx_count_q;

    // A zero count still moves one byte; oversize counts saturate at the per-CS limit
    always_comb begin
        count_clamped = i_TX_Count;
        if (i_TX_Count == '0) begin
            count_clamped = CW'(1);
        end else if (i_TX_Count > CW'(MAX_BYTES_PER_CS)) begin
            count_clamped = CW'(MAX_BYTES_PER_CS);
        end
    end

    // CS state, byte bookkeeping and handshake next-state
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rx_count_d  = rx_count_q;
        inact_d     = inact_q;
        cs_n_d      = cs_n_q;
        ready_d     = ready_q;
        case (state_q)
            IDLE: begin
                cs_n_d     = 1'b1;
                ready_d    = 1'b1;
                rx_count_d = '0;
                inact_d    = '0;
                if (accept) begin
                    remaining_d = count_clamped;
                    cs_n_d      = 1'b0;
                    ready_d     = 1'b0;
                    state_d     = TRANSFER;
                end
            end
            TRANSFER: begin
                cs_n_d = 1'b0;
                if (accept) begin
                    ready_d = 1'b0;
                end
                // Book-keeping runs on the last edge so ready and the RX count line up with the done pulse
                if (last_edge) begin
                    remaining_d = remaining_q - CW'(1);
                    rx_count_d  = rx_count_q + CW'(1);
                    if (remaining_q <= CW'(1)) begin
                        ready_d = 1'b0;
                        inact_d = '0;
                        state_d = CS_INACTIVE;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
            end
            CS_INACTIVE: begin
                cs_n_d  = 1'b1;
                ready_d = 1'b0;
                if (inact_q == IW'(CS_INACTIVE_CLKS)) begin
                    ready_d    = 1'b1;
                    rx_count_d = '0;
                    state_d    = IDLE;
                end else begin
                    inact_d = inact_q + IW'(1);
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Controller state register; ready stays low through reset and rises on the first clock after
    always_ff @(posedge sys_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rx_count_q  <= '0;
            inact_q     <= '0;
            cs_n_q      <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rx_count_q  <= rx_count_d;
            inact_q     <= inact_d;
            cs_n_q      <= cs_n_d;
            ready_q     <= ready_d;
        end
    end

    spi_byte_engine #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_engine (
        .sys_clk     (sys_clk),
        .i_Rst_L     (i_Rst_L),
        .i_start     (accept),
        .i_byte      (i_TX_Byte),
        .i_miso      (i_SPI_MISO),
        .o_sclk      (o_SPI_Clk),
        .o_mosi      (o_SPI_MOSI),
        .o_last_edge (last_edge),
        .o_done      (o_RX_DV),
        .o_rx_byte   (o_RX_Byte)
    );

endmodule

// File: tb/tb_spi_master_cs.sv
// tb/tb_spi_master_cs.sv - self-checking bench for spi_master_cs in modes 0 and 3
module tb_spi_master_cs;

    localparam int CPHB = 2;
    localparam int MAXB = 2;
    localparam int KCS  = 1;
    localparam int CW   = $clog2(MAXB + 1);

    typedef struct {
        logic [7:0] b;
        int         idx;
    } exp_t;

    typedef struct {
        int         inst;
        int         cnt;
        logic [7:0] b0;
        logic [7:0] b1;
        int         nexp;
        int         busy_at;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [CW-1:0] tx_count [2];
    logic [7:0]    tx_byte  [2];
    logic          tx_dv    [2];
    logic          tx_ready [2];
    logic [CW-1:0] rx_count [2];
    logic          rx_dv    [2];
    logic [7:0]    rx_byte  [2];
    logic          sclk     [2];
    logic          mosi     [2];
    logic          cs_n     [2];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   rises    [2];
    int   dv_seen  [2];
    logic [7:0] mcap [2];
    logic psclk    [2];
    logic pmosi    [2];
    vec_t vecs     [7];

    always #5 clk = ~clk;

    spi_master_cs #(
        .SPI_MODE(0), .CLKS_PER_HALF_BIT(CPHB), .MAX_BYTES_PER_CS(MAXB), .CS_INACTIVE_CLKS(KCS)
    ) u_dut0 (
        .sys_clk(clk), .i_Rst_L(rst_l), .i_TX_Count(tx_count[0]), .i_TX_Byte(tx_byte[0]),
        .i_TX_DV(tx_dv[0]), .o_TX_Ready(tx_ready[0]), .o_RX_Count(rx_count[0]), .o_RX_DV(rx_dv[0]),
        .o_RX_Byte(rx_byte[0]), .o_SPI_Clk(sclk[0]), .i_SPI_MISO(mosi[0]), .o_SPI_MOSI(mosi[0]),
        .o_SPI_CS_n(cs_n[0])
    );

    spi_master_cs #(
        .SPI_MODE(3), .CLKS_PER_HALF_BIT(CPHB), .MAX_BYTES_PER_CS(MAXB), .CS_INACTIVE_CLKS(KCS)
    ) u_dut3 (
        .sys_clk(clk), .i_Rst_L(rst_l), .i_TX_Count(tx_count[1]), .i_TX_Byte(tx_byte[1]),
        .i_TX_DV(tx_dv[1]), .o_TX_Ready(tx_ready[1]), .o_RX_Count(rx_count[1]), .o_RX_DV(rx_dv[1]),
        .o_RX_Byte(rx_byte[1]), .o_SPI_Clk(sclk[1]), .i_SPI_MISO(mosi[1]), .o_SPI_MOSI(mosi[1]),
        .o_SPI_CS_n(cs_n[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int k, input logic [7:0] b, input int idx);
        exp_t e;
        e.b   = b;
        e.idx = idx;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic sb_compare(input int k);
        exp_t e;
        int   exp_rx;
        check("rx_expected", (qsize(k) > 0) ? 1 : 0, 1);
        if (qsize(k) > 0) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
`ifdef SPI_RX_EN
            exp_rx = int'(e.b);
`else
            exp_rx = 0;
`endif
            check("rx_byte", int'(rx_byte[k]), exp_rx);
            check("rx_count", int'(rx_count[k]), e.idx);
            check("mosi_byte", int'(mcap[k]), int'(e.b));
            check("sclk_rises", rises[k], 8);
            check("sclk_idle_at_dv", int'(sclk[k]), k);
        end
    endtask

    // Monitor: rebuild MOSI bytes from rising SCLK edges and score every RX_DV pulse
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_l) begin
                rises[k] = 0;
                mcap[k]  = 8'h00;
                psclk[k] = (k == 1);
                pmosi[k] = 1'b0;
            end else begin
                if (sclk[k] && !psclk[k]) begin
                    check("mosi_stable_on_rise", int'(mosi[k]), int'(pmosi[k]));
                    mcap[k] = {mcap[k][6:0], mosi[k]};
                    rises[k]++;
                end
                if (rx_dv[k]) begin
                    dv_seen[k]++;
                    sb_compare(k);
                    rises[k] = 0;
                end
                psclk[k] = sclk[k];
                pmosi[k] = mosi[k];
            end
        end
    end

    task automatic check_reset_outputs(input int k);
        check("rst_ready", int'(tx_ready[k]), 0);
        check("rst_rx_dv", int'(rx_dv[k]), 0);
        check("rst_rx_byte", int'(rx_byte[k]), 0);
        check("rst_rx_count", int'(rx_count[k]), 0);
        check("rst_sclk", int'(sclk[k]), k);
        check("rst_mosi", int'(mosi[k]), 0);
        check("rst_cs_n", int'(cs_n[k]), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int w;
        int cs_low;
        int sent;
        int gap;
        int dv0;
        k = v.inst;
        w = 0;
        while (!tx_ready[k] && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_txn", int'(tx_ready[k]), 1);
        dv0         = dv_seen[k];
        tx_count[k] = CW'(v.cnt);
        tx_byte[k]  = v.b0;
        tx_dv[k]    = 1'b1;
        push(k, v.b0, 1);
        sent = 1;
        @(negedge clk);
        tx_dv[k] = 1'b0;
        if (k == 0) check("mosi_bit7_t1", int'(mosi[0]), int'(v.b0[7]));
        check("cs_low_t1", int'(cs_n[k]), 0);
        cs_low = 0;
        while (cs_n[k] == 1'b0 && cs_low < 400) begin
            cs_low++;
            if (tx_ready[k] && sent < v.nexp) begin
                tx_byte[k] = v.b1;
                tx_dv[k]   = 1'b1;
                sent++;
                push(k, v.b1, 2);
            end else if (cs_low == v.busy_at) begin
                tx_byte[k] = 8'hFF;
                tx_dv[k]   = 1'b1;
            end
            @(negedge clk);
            tx_dv[k] = 1'b0;
        end
        check("cs_low_cycles", cs_low, 33 * v.nexp);
        gap = 0;
        while (!tx_ready[k] && gap < 50) begin
            check("cs_high_in_gap", int'(cs_n[k]), 1);
            gap++;
            @(negedge clk);
        end
        check("cs_inactive_cycles", gap, KCS);
        check("rx_count_cleared", int'(rx_count[k]), 0);
        check("dv_pulses", dv_seen[k] - dv0, v.nexp);
        check("scoreboard_drained", qsize(k), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0;
        for (int k = 0; k < 2; k++) begin
            tx_dv[k]    = 1'b0;
            tx_byte[k]  = 8'h00;
            tx_count[k] = '0;
            dv_seen[k]  = 0;
        end
        rst_l = 1'b0;
        //         inst cnt  b0     b1     nexp busy_at
        vecs[0] = '{0,   1,   8'h1C, 8'h00, 1,   0};
        vecs[1] = '{0,   2,   8'hBE, 8'hEF, 2,   0};
        vecs[2] = '{1,   1,   8'hA5, 8'h00, 1,   0};
        vecs[3] = '{0,   1,   8'h3C, 8'h00, 1,   10};
        vecs[4] = '{0,   0,   8'h81, 8'h00, 1,   0};
        vecs[5] = '{0,   3,   8'h5A, 8'hC3, 2,   0};
        vecs[6] = '{1,   2,   8'h00, 8'hFF, 2,   20};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_reset_outputs(k);
        #2 rst_l = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("ready_after_reset", int'(tx_ready[k]), 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of bit 4 of 0xFF: nothing may be reported for the partial byte
        dv0         = dv_seen[0];
        tx_count[0] = CW'(1);
        tx_byte[0]  = 8'hFF;
        tx_dv[0]    = 1'b1;
        @(negedge clk);
        tx_dv[0] = 1'b0;
        repeat (13) @(negedge clk);
        check("mid_mosi_bit4", int'(mosi[0]), 1);
        check("mid_cs_low", int'(cs_n[0]), 0);
        #2 rst_l = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_reset_outputs(k);
        @(negedge clk);
        #2 rst_l = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", int'(tx_ready[0]), 1);
        check("cs_after_mid_reset", int'(cs_n[0]), 1);
        repeat (40) @(negedge clk);
        check("no_dv_after_mid_reset", dv_seen[0] - dv0, 0);
        check("scoreboard_empty_end", qsize(0) + qsize(1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
